network: RTL and testbench

Fixed-point two-layer perceptron that classifies one 9-sample frame. It sits between the UART frame assembler and the result transmitter in `top`. On `start` it latches nine signed 17-bit inputs and runs a hidden layer of 4 ReLU neurons and a single linear output neuron on one shared multiplier. It then presents a signed 27-bit score on `out_2` with a one-cycle `end_2` strobe; the caller treats `out_2 > 0` as class 1.

---
 rtl/network_pkg.sv | 35 +++
 rtl/network_mac.sv | 29 ++
 rtl/network.sv | 132 +++++++++++++
 tb/tb_network.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Constants, weights and state encoding shared by the perceptron and its MAC.
package network_pkg;

    localparam int IN_W   = 17;
    localparam int OUT_W  = 27;
    localparam int HID    = 4;
    localparam int N_IN   = 9;
    localparam int SHIFT  = 6;
    localparam int W_W    = 8;
    localparam int H_W    = 16;
    localparam int OP_W   = 18;
    localparam int PROD_W = 26;
    localparam int ACC_W  = 29;

    typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_OUT} state_t;

    // Hidden-layer weights, Q1.6.
    localparam logic signed [W_W-1:0] W1 [HID][N_IN] = '{
        '{8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64},
        '{8'sd127, -8'sd127, 8'sd100, 8'sd50, -8'sd20, 8'sd10, 8'sd5, -8'sd3, 8'sd1},
        '{-8'sd64, 8'sd96, 8'sd32, -8'sd16, 8'sd48, 8'sd8, -8'sd4, 8'sd2, 8'sd0},
        '{8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16, 8'sd16, -8'sd1, -8'sd2, 8'sd3}
    };

    // Hidden biases at product scale (before the >>> SHIFT).
    localparam logic signed [ACC_W-1:0] B1 [HID] = '{
        29'sd6400, -29'sd12800, 29'sd640000, 29'sd5000000
    };

    localparam logic signed [W_W-1:0]   W2 [HID] = '{8'sd3, -8'sd2, 8'sd1, -8'sd1};
    localparam logic signed [OUT_W-1:0] B2       = 27'sd1000;

    localparam logic signed [ACC_W-1:0] H_MAX = 29'sd65535;

endpackage

// File: rtl/network_mac.sv
// Shared signed multiply-accumulate: 18b x 8b product into a 29b accumulator.
// Latency 1 cycle per term; clear has priority over accumulate; no backpressure.
module network_mac
    import network_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [W_W-1:0]    b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(a) * PROD_W'(b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/network.sv
// Two-layer fixed-point perceptron (9 inputs, 4 ReLU hidden, 1 linear output) on one MAC.
// Latency 45 cycles from start to end_2; start is only sampled in IDLE, no other backpressure.
module network
    import network_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  input_0,
    input  logic signed [IN_W-1:0]  input_1,
    input  logic signed [IN_W-1:0]  input_2,
    input  logic signed [IN_W-1:0]  input_3,
    input  logic signed [IN_W-1:0]  input_4,
    input  logic signed [IN_W-1:0]  input_5,
    input  logic signed [IN_W-1:0]  input_6,
    input  logic signed [IN_W-1:0]  input_7,
    input  logic signed [IN_W-1:0]  input_8,
    input  logic                    start,
    output logic signed [OUT_W-1:0] out_2,
    output logic                    end_2
);

    state_t                   state;
    logic [3:0]               i;
    logic [1:0]               j;
    logic [1:0]               k;
    logic signed [IN_W-1:0]   x [N_IN];
    logic [H_W-1:0]           h [HID];

    logic                     mac_clr;
    logic                     mac_en;
    logic signed [OP_W-1:0]   mac_a;
    logic signed [W_W-1:0]    mac_b;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  pre;
    logic signed [ACC_W-1:0]  t;
    logic [H_W-1:0]           h_nxt;

    // Layer 1 feeds sign-extended samples; layer 2 feeds zero-extended hidden values.
    always_comb begin
        mac_a = OP_W'(x[i]);
        mac_b = W1[j][i];
        if (state == L2_MAC) begin
            mac_a = {2'b00, h[k]};
            mac_b = W2[k];
        end
    end

    assign mac_en  = (state == L1_MAC) || (state == L2_MAC);
    assign mac_clr = ((state == IDLE) && start) || (state == L1_ACT);

    network_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    assign pre = acc + B1[j];
    assign t   = pre >>> SHIFT;

    always_comb begin
        h_nxt = t[H_W-1:0];
        if (t < 0) begin
            h_nxt = '0;
        end else if (t > H_MAX) begin
            h_nxt = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            out_2 <= '0;
            end_2 <= 1'b0;
            for (int n = 0; n < N_IN; n++) x[n] <= '0;
            for (int n = 0; n < HID; n++)  h[n] <= '0;
        end else begin
            end_2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x[0]  <= input_0;
                        x[1]  <= input_1;
                        x[2]  <= input_2;
                        x[3]  <= input_3;
                        x[4]  <= input_4;
                        x[5]  <= input_5;
                        x[6]  <= input_6;
                        x[7]  <= input_7;
                        x[8]  <= input_8;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= L1_MAC;
                    end
                end
                L1_MAC: begin
                    if (i == 4'(N_IN - 1)) state <= L1_ACT;
                    else                   i <= i + 4'd1;
                end
                L1_ACT: begin
                    h[j] <= h_nxt;
                    i    <= '0;
                    j    <= j + 2'd1;
                    if (j == 2'(HID - 1)) begin
                        k     <= '0;
                        state <= L2_MAC;
                    end else begin
                        state <= L1_MAC;
                    end
                end
                L2_MAC: begin
                    if (k == 2'(HID - 1)) state <= L2_OUT;
                    else                  k <= k + 2'd1;
                end
                L2_OUT: begin
                    out_2 <= OUT_W'(acc + ACC_W'(B2));
                    end_2 <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_network.sv
// Directed table-driven bench for the perceptron plus multi-cycle handshake/reset sequences.
module tb_network;
    import network_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic signed [16:0]       drv [9];
    logic signed [26:0]       out_2;
    logic                     end_2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string  name;
        int     v [9];
        longint exp;
    } vec_t;

    vec_t tab [6];

    always #5 clk = ~clk;

    network dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .input_0 (drv[0]),
        .input_1 (drv[1]),
        .input_2 (drv[2]),
        .input_3 (drv[3]),
        .input_4 (drv[4]),
        .input_5 (drv[5]),
        .input_6 (drv[6]),
        .input_7 (drv[7]),
        .input_8 (drv[8]),
        .start   (start),
        .out_2   (out_2),
        .end_2   (end_2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int v [9]);
        for (int n = 0; n < 9; n++) drv[n] = 17'(v[n]);
    endtask

    // Reference model in wide integer arithmetic.
    function automatic longint model(input int v [9]);
        longint s, tt, hv, o;
        o = longint'(B2);
        for (int jj = 0; jj < 4; jj++) begin
            s = longint'(B1[jj]);
            for (int ii = 0; ii < 9; ii++) s += longint'(v[ii]) * longint'(W1[jj][ii]);
            tt = s >>> 6;
            hv = (tt < 0) ? 0 : ((tt > 65535) ? 65535 : tt);
            o += hv * longint'(W2[jj]);
        end
        return o;
    endfunction

    task automatic wait_end(input int limit, input int chg_at, input int alt [9], output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (c == chg_at) load(alt);
            if (end_2 === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input int v [9], input longint exp,
                           input int chg_at, input int alt [9]);
        int lat;
        load(v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_end(60, chg_at, alt, lat);
        chk({name, " latency"}, lat, 45);
        chk({name, " out_2"}, out_2, exp);
        @(posedge clk);
        #1;
        chk({name, " end_2 drop"}, end_2, 0);
        chk({name, " out_2 hold"}, out_2, exp);
    endtask

    initial begin
        int lat, n_end, first;
        int ends [$];

        tab[0].name = "zero";
        tab[0].v    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[0].exp  = -54235;
        tab[1].name = "max";
        tab[1].v    = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
        tab[1].exp  = 66535;
        tab[2].name = "min";
        tab[2].v    = '{-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536};
        tab[2].exp  = 1000;
        tab[3].name = "alt";
        tab[3].v    = '{1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000, 9000};
        tab[3].exp  = model(tab[3].v);
        tab[4].name = "ramp";
        tab[4].v    = '{100, 200, 300, 400, 500, 600, 700, 800, 900};
        tab[4].exp  = model(tab[4].v);
        tab[5].name = "mixed";
        tab[5].v    = '{65535, -65536, 0, 1, -1, 12345, -12345, 32767, -32768};
        tab[5].exp  = model(tab[5].v);

        // Reset held with start asserted, then first result after release.
        load(tab[0].v);
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset out_2", out_2, 0);
            chk("reset end_2", end_2, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_end(60, 0, tab[0].v, lat);
        chk("post-reset latency", lat, 45);
        chk("post-reset out_2", out_2, tab[0].exp);
        @(posedge clk);
        #1;

        for (int n = 0; n < 6; n++) run_vec(tab[n].name, tab[n].v, tab[n].exp, 0, tab[n].v);

        // Inputs change mid-run; result must follow the latched frame.
        run_vec("stability", tab[3].v, tab[3].exp, 5, tab[4].v);

        // start pulse while busy is ignored.
        load(tab[4].v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_end = 0;
        first = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 12) start = 1'b1;
            if (c == 13) start = 1'b0;
            if (end_2 === 1'b1) begin
                n_end++;
                if (first < 0) first = c;
            end
        end
        chk("busy end count", n_end, 1);
        chk("busy latency", first, 45);
        chk("busy out_2", out_2, tab[4].exp);

        // Level start: back-to-back runs.
        load(tab[5].v);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 137; c++) begin
            @(posedge clk);
            #1;
            if (end_2 === 1'b1) ends.push_back(c);
            if (c == 137) start = 1'b0;
        end
        chk("level end count", ends.size(), 3);
        chk("level end #1", (ends.size() > 0) ? ends[0] : -1, 45);
        chk("level end #2", (ends.size() > 1) ? ends[1] : -1, 91);
        chk("level end #3", (ends.size() > 2) ? ends[2] : -1, 137);
        chk("level out_2", out_2, tab[5].exp);
        n_end = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (end_2 === 1'b1) n_end++;
        end
        chk("level idle after drop", n_end, 0);

        // Abort mid-run via reset.
        load(tab[3].v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_end = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (end_2 === 1'b1) n_end++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort out_2 cleared", out_2, 0);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (end_2 === 1'b1) n_end++;
        end
        chk("abort no end_2", n_end, 0);
        chk("abort out_2 stays 0", out_2, 0);
        run_vec("after abort", tab[4].v, tab[4].exp, 0, tab[4].v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
